// File: rtl/uart_loader.sv
// uart_loader: serial monitor/bootloader that writes, reads back and launches programs in the shared RAM
module uart_loader #(
    parameter int ADDR_W   = 9,
    parameter int RD_LAT   = 2,
    parameter int TIMEOUT  = 1200000,
    parameter int TX_GUARD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              received,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              is_transmitting,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [7:0]        ram_rdata,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] cpu_startaddr,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              cpu_owns_bus,
    output logic              busy
);
    typedef enum logic [3:0] {IDLE, HDR, WDATA, RADDR, RWAIT, RSEND, GO, RUN, ACK} state_t;
    localparam logic [3:0]  LAT_END = 4'(RD_LAT);
    localparam logic [20:0] TO_END  = 21'(TIMEOUT);
    localparam logic [3:0]  G_INIT  = 4'(TX_GUARD);
    state_t state, state_n;
    logic [7:0] cmd, ack_byte, ack_n, rd_byte;
    logic [1:0] hdr_cnt;
    logic [ADDR_W-1:0] addr;
    logic [8:0] n;
    logic [20:0] to_cnt;
    logic [3:0] lat, guard;
    logic tx_ok, timed_out, is_cmd;
    assign tx_ok = guard == 4'd0 && !is_transmitting;
    assign timed_out = to_cnt == TO_END && !received;
    assign is_cmd = rx_byte == 8'h57 || rx_byte == 8'h52 || rx_byte == 8'h47;
    assign busy = state != IDLE;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // next state and the byte to acknowledge with when entering ACK
    always_comb begin
        state_n = state;
        ack_n = ack_byte;
        case (state)
            IDLE: if (received) begin
                state_n = is_cmd ? HDR : ACK;
                ack_n = 8'h3F;
            end
            HDR: if (received) begin
                if (hdr_cnt == 2'd1 && cmd == 8'h47) state_n = GO;
                else if (hdr_cnt == 2'd2) state_n = cmd == 8'h57 ? WDATA : RADDR;
            end else if (timed_out) begin
                state_n = ACK;
                ack_n = 8'h3F;
            end
            WDATA: if (received && n == 9'd1) begin
                state_n = ACK;
                ack_n = 8'h2E;
            end else if (timed_out) begin
                state_n = ACK;
                ack_n = 8'h3F;
            end
            RADDR: state_n = RWAIT;
            RWAIT: state_n = lat == LAT_END ? RSEND : RWAIT;
            RSEND: if (tx_ok) begin
                state_n = n == 9'd1 ? ACK : RADDR;
                ack_n = 8'h2E;
            end
            GO: state_n = RUN;
            RUN: if (cpu_halted) begin
                state_n = ACK;
                ack_n = 8'h48;
            end
            ACK: state_n = tx_ok ? IDLE : ACK;
            default: state_n = IDLE;
        endcase
    end
    // datapath: header capture, RAM strobes, transmit pacing, CPU handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            {cmd, ack_byte, rd_byte, hdr_cnt, addr, n, to_cnt, lat, guard} <= '0;
            {tx_byte, transmit, ram_raddr, ram_waddr, ram_wdata, ram_we} <= '0;
            {cpu_startaddr, cpu_run, cpu_owns_bus} <= '0;
        end else begin
            ram_we <= 1'b0;
            transmit <= 1'b0;
            cpu_run <= 1'b0;
            ack_byte <= ack_n;
            guard <= guard != 4'd0 ? guard - 1'b1 : guard;
            to_cnt <= (state == HDR || state == WDATA) && !received && state_n == state ? to_cnt + 1'b1 : '0;
            case (state)
                IDLE: if (received) begin
                    cmd <= rx_byte;
                    hdr_cnt <= 2'd0;
                end
                HDR: if (received) begin
                    hdr_cnt <= hdr_cnt + 1'b1;
                    if (hdr_cnt == 2'd0) addr[8] <= rx_byte[0];
                    if (hdr_cnt == 2'd1) addr[7:0] <= rx_byte;
                    if (hdr_cnt == 2'd2) n <= rx_byte == 8'h00 ? 9'h100 : {1'b0, rx_byte};
                end
                WDATA: if (received) begin
                    ram_we <= 1'b1;
                    ram_waddr <= addr;
                    ram_wdata <= rx_byte;
                    addr <= addr + 1'b1;
                    n <= n - 1'b1;
                end
                RADDR: begin
                    ram_raddr <= addr;
                    lat <= 4'd0;
                end
                RWAIT: begin
                    lat <= lat + 1'b1;
                    if (lat == LAT_END) rd_byte <= ram_rdata;
                end
                RSEND: if (tx_ok) begin
                    transmit <= 1'b1;
                    tx_byte <= rd_byte;
                    guard <= G_INIT;
                    addr <= addr + 1'b1;
                    n <= n - 1'b1;
                end
                GO: begin
                    cpu_startaddr <= addr;
                    cpu_owns_bus <= 1'b1;
                    cpu_run <= 1'b1;
                end
                RUN: if (cpu_halted) cpu_owns_bus <= 1'b0;
                ACK: if (tx_ok) begin
                    transmit <= 1'b1;
                    tx_byte <= ack_byte;
                    guard <= G_INIT;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed checks of the loader's write, read, go, error and timeout paths
module tb_uart_loader;
    localparam int TO = 100;
    logic clk, rst, received, is_transmitting, transmit, ram_we, cpu_run, cpu_halted, cpu_owns_bus, busy;
    logic [7:0] rx_byte, tx_byte, ram_rdata, ram_wdata, p1;
    logic [8:0] ram_raddr, ram_waddr, cpu_startaddr;
    logic [7:0] mem [512];
    logic [7:0] txq [$];
    logic [16:0] weq [$];
    int errors = 0, checks = 0, viol = 0, runs = 0, txbusy = 0;

    uart_loader #(.ADDR_W(9), .RD_LAT(2), .TIMEOUT(TO), .TX_GUARD(2)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received), .tx_byte(tx_byte),
        .transmit(transmit), .is_transmitting(is_transmitting), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cpu_startaddr(cpu_startaddr), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .cpu_owns_bus(cpu_owns_bus), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    assign is_transmitting = txbusy != 0;

    // two-stage read pipeline models RD_LAT=2
    always @(posedge clk) begin
        p1 <= mem[ram_raddr];
        ram_rdata <= p1;
    end

    // mid-cycle monitors: RAM writes, UART transmits (busy 50 cycles), CPU launches
    always @(negedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
            weq.push_back({ram_waddr, ram_wdata});
        end
        if (transmit) begin
            txq.push_back(tx_byte);
            if (is_transmitting) viol++;
            txbusy <= 50;
        end else if (txbusy != 0) txbusy <= txbusy - 1;
        if (cpu_run) runs++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk) #1;
        rx_byte = b;
        received = 1;
        @(posedge clk) #1;
        received = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_tx(input int cnt, input int budget);
        int i = 0;
        while (txq.size() < cnt && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (txq.size() < cnt) chk("tx_wait", 64'(txq.size()), 64'(cnt));
        #1;
    endtask

    function automatic logic [47:0] outs();
        return {tx_byte, transmit, ram_raddr, ram_waddr, ram_wdata, ram_we, cpu_startaddr, cpu_run, cpu_owns_bus, busy};
    endfunction

    initial begin
        rst = 1; received = 0; rx_byte = 0; cpu_halted = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 48'h0);
        rst = 0;

        send(8'h57); send(8'h01); send(8'h10); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        wait_tx(1, 40);
        chk("w_ack", txq[0], 8'h2E);
        chk("w_cnt", 64'(weq.size()), 3);
        chk("w0", weq[0], {9'h110, 8'hAA});
        chk("w1", weq[1], {9'h111, 8'hBB});
        chk("w2", weq[2], {9'h112, 8'hCC});
        txq.delete(); weq.delete();

        repeat (60) @(posedge clk);
        send(8'h57); send(8'h01); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
        wait_tx(1, 80);
        chk("wrap_ack", txq[0], 8'h2E);
        chk("wrap_cnt", 64'(weq.size()), 2);
        chk("wrap0", weq[0], {9'h1FF, 8'h11});
        chk("wrap1", weq[1], {9'h000, 8'h22});
        txq.delete(); weq.delete();

        repeat (60) @(posedge clk);
        send(8'h52); send(8'h01); send(8'h10); send(8'h03);
        wait_tx(4, 400);
        chk("r0", txq[0], 8'hAA);
        chk("r1", txq[1], 8'hBB);
        chk("r2", txq[2], 8'hCC);
        chk("r_ack", txq[3], 8'h2E);
        chk("r_viol", 64'(viol), 0);
        chk("r_nowrite", 64'(weq.size()), 0);
        txq.delete();

        repeat (60) @(posedge clk);
        cpu_halted = 1;
        @(posedge clk) #1;
        cpu_halted = 0;
        repeat (10) @(posedge clk);
        chk("halt_idle_ignored", 64'(txq.size()), 0);

        send(8'h47); send(8'h00); send(8'h20);
        chk("go_owns", cpu_owns_bus, 1'b1);
        chk("go_start", cpu_startaddr, 9'h020);
        send(8'h57); send(8'h00); send(8'h00); send(8'h01); send(8'h55);
        repeat (20) @(posedge clk);
        #1;
        chk("run_once", 64'(runs), 1);
        chk("run_nowrite", 64'(weq.size()), 0);
        chk("run_notx", 64'(txq.size()), 0);
        chk("run_busy", busy, 1'b1);
        @(posedge clk) #1;
        cpu_halted = 1;
        @(posedge clk) #1;
        cpu_halted = 0;
        chk("halt_release", cpu_owns_bus, 1'b0);
        wait_tx(1, 20);
        chk("halt_ack", txq[0], 8'h48);
        txq.delete();

        repeat (60) @(posedge clk);
        send(8'h5A);
        wait_tx(1, 20);
        chk("bad_cmd", txq[0], 8'h3F);
        txq.delete();

        repeat (60) @(posedge clk);
        send(8'h57); send(8'h00);
        repeat (TO - 10) @(posedge clk);
        chk("to_early", 64'(txq.size()), 0);
        repeat (15) @(posedge clk);
        wait_tx(1, 20);
        chk("to_ack", txq[0], 8'h3F);
        chk("to_nowrite", 64'(weq.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_idle", busy, 1'b0);
        txq.delete();

        repeat (60) @(posedge clk);
        send(8'h57); send(8'h01); send(8'h40); send(8'h03); send(8'h77);
        @(posedge clk) #1;
        rst = 1;
        @(posedge clk) #1;
        chk("rst_outs", outs(), 48'h0);
        rst = 0;
        repeat (5) @(posedge clk);
        chk("rst_one_write", 64'(weq.size()), 1);
        chk("rst_write0", weq[0], {9'h140, 8'h77});
        weq.delete();
        send(8'h57); send(8'h01); send(8'h50); send(8'h01); send(8'h99);
        wait_tx(1, 40);
        chk("post_rst_ack", txq[0], 8'h2E);
        chk("post_rst_cnt", 64'(weq.size()), 1);
        chk("post_rst_w", weq[0], {9'h150, 8'h99});
        chk("final_viol", 64'(viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
